// File: rtl/sonic_pkg.sv
// rtl/sonic_pkg.sv - shared state encoding and distance constants for the sonic scheduler
package sonic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    RESULT,
    GAP
  } state_t;

  localparam int US_PER_CM = 59;
  localparam int DIST_W = 10;
  localparam logic [DIST_W-1:0] DIST_TIMEOUT = 10'd1023;

  // Round-trip echo time in us to one-way distance in cm
  function automatic logic [DIST_W-1:0] us_to_cm(input logic [15:0] us);
    return DIST_W'(us / 16'(US_PER_CM));
  endfunction

endpackage

// File: rtl/us_tick.sv
// rtl/us_tick.sv - free-running divider producing a one-cycle pulse every microsecond
module us_tick #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sonic_scheduler.sv
// rtl/sonic_scheduler.sv - round-robin trigger/echo timing shared across ultrasonic sensors
module sonic_scheduler
  import sonic_pkg::*;
#(
  parameter int N_SENSORS       = 4,
  parameter int CLK_HZ          = 100_000_000,
  parameter int TRIG_US         = 10,
  parameter int RISE_TIMEOUT_US = 2000,
  parameter int ECHO_MAX_US     = 30000,
  parameter int GAP_US          = 60000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [N_SENSORS-1:0]        echo,
  output logic [N_SENSORS-1:0]        trig,
  output logic [DIST_W*N_SENSORS-1:0] distance,
  output logic [N_SENSORS-1:0]        timeout,
  output logic                        valid,
  output logic [2:0]                  valid_idx,
  output logic                        busy
);

  state_t state, state_next;
  logic [2:0] cur;
  logic [15:0] us_cnt;
  logic tick;
  logic res_to;

  logic [N_SENSORS-1:0] echo_s1, echo_s2, echo_s3, rise_q, fall_q;
  logic [7:0] rise8, fall8;
  logic [N_SENSORS-1:0] trig_sel;

  us_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Every pin is synchronized so switching cur never fabricates an edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      echo_s1 <= '0;
      echo_s2 <= '0;
      echo_s3 <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
      echo_s3 <= echo_s2;
      rise_q  <= echo_s2 & ~echo_s3;
      fall_q  <= ~echo_s2 & echo_s3;
    end
  end

  assign rise8    = 8'(rise_q);
  assign fall8    = 8'(fall_q);
  assign trig_sel = N_SENSORS'(8'd1 << cur);
  assign busy     = (state != IDLE);

  // Edges take priority over the timeout checks in the same cycle
  always_comb begin
    state_next = state;
    res_to     = 1'b0;
    case (state)
      IDLE:      if (enable) state_next = TRIG;
      TRIG:      if (us_cnt == 16'(TRIG_US)) state_next = WAIT_RISE;
      WAIT_RISE: begin
        if (rise8[cur]) begin
          state_next = MEASURE;
        end else if (us_cnt == 16'(RISE_TIMEOUT_US)) begin
          state_next = RESULT;
          res_to     = 1'b1;
        end
      end
      MEASURE: begin
        if (fall8[cur]) begin
          state_next = RESULT;
        end else if (us_cnt == 16'(ECHO_MAX_US)) begin
          state_next = RESULT;
          res_to     = 1'b1;
        end
      end
      RESULT:    state_next = GAP;
      GAP:       if (us_cnt == 16'(GAP_US)) state_next = enable ? TRIG : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      us_cnt <= '0;
      cur    <= '0;
      trig   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        us_cnt <= '0;
      end else if (tick) begin
        us_cnt <= us_cnt + 16'd1;
      end
      if (state == GAP && state_next != GAP) begin
        cur <= (cur == 3'(N_SENSORS - 1)) ? 3'd0 : cur + 3'd1;
      end
      trig <= (state == TRIG) ? trig_sel : '0;
    end
  end

  // Results land on the edge that enters RESULT, so valid and data share a cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      distance  <= '0;
      timeout   <= '0;
      valid     <= 1'b0;
      valid_idx <= '0;
    end else begin
      valid <= 1'b0;
      if (state_next == RESULT && state != RESULT) begin
        valid     <= 1'b1;
        valid_idx <= cur;
        for (int i = 0; i < N_SENSORS; i++) begin
          if (3'(i) == cur) begin
            distance[DIST_W*i +: DIST_W] <= res_to ? DIST_TIMEOUT : us_to_cm(us_cnt);
            timeout[i]                   <= res_to;
          end
        end
      end
    end
  end

endmodule

// File: doc/sonic_scheduler.md
# sonic_scheduler

Round-robin controller that shares one echo-timing datapath among up to N ultrasonic sensors. It fires each sensor's trigger in turn, times only the selected sensor's echo, converts the pulse width to centimetres and stores a per-sensor distance. Sensors are never fired together, so there is no acoustic crosstalk. It sits between the sensor pins and the application logic, and replaces one-sensor-per-instance sonic interfaces.

## Interface
- N_SENSORS, 4: number of sensors served, 1..8
- CLK_HZ, 100_000_000: clk frequency; one 1 us tick every CLK_HZ/1_000_000 cycles
- TRIG_US, 10: trigger pulse width in us
- RISE_TIMEOUT_US, 2000: maximum wait from trigger end to echo rise
- ECHO_MAX_US, 30000: maximum echo high time
- GAP_US, 60000: settle time after each measurement before the next sensor fires
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- enable  in  1  run the round-robin sequence
- echo  in  N_SENSORS  raw sensor echo pins, asynchronous
- trig  out  N_SENSORS  trigger pins, one-hot or zero
- distance  out  10*N_SENSORS  flattened per-sensor distance in cm; sensor i occupies [10i+9:10i]
- timeout  out  N_SENSORS  per-sensor flag: last measurement timed out
- valid  out  1  one-cycle pulse when a result is written
- valid_idx  out  3  index of the sensor whose result was just written
- busy  out  1  high in every state except IDLE

## Operation
- Reset values: trig=0, distance=0, timeout=0, valid=0, valid_idx=0, busy=0, cur=0, state=IDLE, us counter=0.
- Echo inputs pass through a 2-flop synchronizer and then an edge register. Only echo[cur] is examined; the other echo bits are ignored.
- A free-running tick counter divides clk to a 1 us tick. The state's us counter clears on each state entry and increments on each tick. Resolution is +/-1 us.
- State transitions:
  - IDLE: when enable=1, go to TRIG.
  - TRIG: trig[cur]=1. After TRIG_US ticks, go to WAIT_RISE.
  - WAIT_RISE: on a synchronized rising edge of echo[cur], go to MEASURE. If RISE_TIMEOUT_US ticks pass first, go to RESULT with to=1.
  - MEASURE: count us while echo is high. On the falling edge, go to RESULT with to=0. If the count reaches ECHO_MAX_US, go to RESULT with to=1.
  - RESULT (1 cycle): distance[cur] = to ? 1023 : count/59. timeout[cur]=to. valid=1, valid_idx=cur. Go to GAP.
  - GAP: after GAP_US ticks, cur = (cur==N_SENSORS-1) ? 0 : cur+1. Go to TRIG if enable=1, otherwise IDLE.
- Arithmetic: us count is 16 bits, unsigned. Divide by the constant 59 (us per cm, round trip). Result is 10 bits; ECHO_MAX_US/59 = 508, so no saturation is needed except the 1023 timeout code.
- enable is sampled only in IDLE and at the end of GAP. Deasserting it mid-sequence lets the current sensor finish through GAP.
- Reset mid-operation is immediate and asynchronous. trig drops the same instant, and all stored distances clear.

## Timing
- trig[cur] rises 1 clk after TRIG is entered. It stays high for exactly TRIG_US ticks, ±1 tick of phase.
- valid pulses exactly 4 clk after the echo pin falls: 2 sync flops, 1 edge detect, 1 RESULT register.
- distance and timeout update in the same cycle as valid and hold until that sensor's next RESULT.
- An echo already high when WAIT_RISE is entered is not counted as a rise. A rising edge is required.
- If rise timeout and a rise arrive in the same cycle, the rise wins. If ECHO_MAX and a fall arrive in the same cycle, the fall wins.
- Full cycle period per sensor is at most TRIG_US + RISE_TIMEOUT_US + ECHO_MAX_US + GAP_US us.

## Structure
- Shared package sonic_pkg holds:
  - the state enum (IDLE, TRIG, WAIT_RISE, MEASURE, RESULT, GAP);
  - US_PER_CM=59;
  - DIST_W=10;
  - DIST_TIMEOUT=10'd1023.
- One sub-module, us_tick: parameterized tick generator that outputs a 1-cycle pulse every CLK_HZ/1e6 clocks. It is reused for all timing.
- Synchronizer and edge detection stay inline.

## Test plan
- Reset: pull rst=0 during MEASURE of sensor 1. Required: trig=0, all distance=0, valid=0 at once. After release with enable=1, the first trig pulse goes on sensor 0.
- Normal: echo[0] rises 500 us after trig falls and stays high 1180 us. Required: distance[0]=20, timeout[0]=0, a single valid pulse with valid_idx=0, 4 clk after echo falls.
- No echo: echo[1] never rises. Required: RESULT 2000 us after trig ends, distance[1]=1023, timeout[1]=1.
- Stuck echo: echo[2] is high for 40000 us. Required: RESULT at 30000 us of MEASURE, distance[2]=1023, timeout[2]=1. The echo is still high when GAP starts.
- Round robin and isolation: N=4 with echoes toggling on unselected sensors. Required: trig fires in order 0,1,2,3,0 with one-hot trig and GAP_US spacing. Unselected echoes do not change any result.
- Enable drop: enable=0 during MEASURE of sensor 2. Required: sensor 2's result is delivered, GAP completes, then IDLE with busy=0 and trig=0. After enable=1, the next trig is on sensor 3.
